// File: rtl/ray_march_stepper_pkg.sv
// Shared fixed-point scalar, vector and stepper types for the ray marcher.
// Q16.16 is used throughout; vec3 packs x in the top bits.
package common_defs;
    typedef logic signed [31:0] fp;
    localparam int FP_FRAC_BITS = 16;
    localparam fp  FP_ONE       = 32'sh0001_0000;
endpackage

package vector_pkg;
    import common_defs::*;
    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;
endpackage

package ray_march_stepper_pkg;
    import common_defs::*;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Signed add that clamps instead of wrapping.
    function automatic fp sat_add(input fp a, input fp b);
        logic signed [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32:31] == 2'b01) return 32'sh7FFF_FFFF;
        if (s[32:31] == 2'b10) return 32'sh8000_0000;
        return s[31:0];
    endfunction
endpackage

// File: rtl/ray_march_stepper_point_eval.sv
// Combinational sample point p = origin + ((t * dir) >>> 16), per component.
module rayPointEval
    import common_defs::*;
    import vector_pkg::*;
(
    input  vec3 origin_i,
    input  vec3 dir_i,
    input  fp   t_i,
    output vec3 p_o
);
    fp o_c [3];
    fp d_c [3];
    fp p_c [3];

    assign o_c[0] = origin_i.x;
    assign o_c[1] = origin_i.y;
    assign o_c[2] = origin_i.z;
    assign d_c[0] = dir_i.x;
    assign d_c[1] = dir_i.y;
    assign d_c[2] = dir_i.z;

    for (genvar gi = 0; gi < 3; gi++) begin : g_comp
        logic signed [63:0] prod;
        assign prod    = 64'(t_i) * 64'(d_c[gi]);
        assign p_c[gi] = o_c[gi] + fp'(prod >>> FP_FRAC_BITS);
    end

    assign p_o = '{x: p_c[0], y: p_c[1], z: p_c[2]};
endmodule

// File: rtl/ray_march_stepper.sv
// Ray-march sequencer: issues sample points to an SDF block one at a time and
// advances t by the returned distance until hit, max distance or step limit.
module ray_march_stepper
    import common_defs::*;
    import vector_pkg::*;
    import ray_march_stepper_pkg::*;
#(
    parameter int MAX_STEPS = 64,
    parameter fp  HIT_EPS   = 32'sd66,
    parameter fp  MAX_DIST  = 32'sh0064_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    output logic       start_ready,
    input  vec3        ray_origin,
    input  vec3        ray_dir,
    output vec3        sdf_p,
    output logic       sdf_valid_out,
    input  fp          sdf_dist,
    input  logic       sdf_valid_in,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_hit,
    output fp          res_t,
    output logic [7:0] res_steps
);
    localparam logic [7:0] MAX_STEPS_U = 8'(MAX_STEPS);

    state_t     state_q;
    vec3        origin_q, dir_q, sdf_p_q;
    fp          t_q, res_t_q;
    logic [7:0] step_q, res_steps_q;
    logic       sdf_valid_q, res_valid_q, res_hit_q;

    fp          t_d;
    logic [7:0] step_d;
    vec3        p_eval;

    rayPointEval u_point_eval (
        .origin_i (origin_q),
        .dir_i    (dir_q),
        .t_i      (t_q),
        .p_o      (p_eval)
    );

    assign t_d    = sat_add(t_q, sdf_dist);
    assign step_d = step_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            origin_q    <= '0;
            dir_q       <= '0;
            t_q         <= '0;
            step_q      <= '0;
            sdf_p_q     <= '0;
            sdf_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_t_q     <= '0;
            res_steps_q <= '0;
        end else begin
            sdf_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        origin_q <= ray_origin;
                        dir_q    <= ray_dir;
                        t_q      <= '0;
                        step_q   <= '0;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    sdf_p_q     <= p_eval;
                    sdf_valid_q <= 1'b1;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sdf_valid_in) begin
                        // Hit is tested first so it wins over both miss conditions.
                        if (sdf_dist < HIT_EPS) begin
                            res_hit_q   <= 1'b1;
                            res_t_q     <= t_q;
                            res_steps_q <= step_d;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (t_d >= MAX_DIST || step_d == MAX_STEPS_U) begin
                            res_hit_q   <= 1'b0;
                            res_t_q     <= t_d;
                            res_steps_q <= step_d;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            t_q     <= t_d;
                            step_q  <= step_d;
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign start_ready   = (state_q == ST_IDLE);
    assign sdf_p         = sdf_p_q;
    assign sdf_valid_out = sdf_valid_q;
    assign res_valid     = res_valid_q;
    assign res_hit       = res_hit_q;
    assign res_t         = res_t_q;
    assign res_steps     = res_steps_q;
endmodule

// File: tb/tb_ray_march_stepper.sv
// Directed bench for ray_march_stepper with an SDF stub and a behavioural march model.
module tb_ray_march_stepper;
    import common_defs::*;
    import vector_pkg::*;

    localparam int MAX_STEPS = 64;
    localparam fp  HIT_EPS   = 32'sd66;
    localparam fp  MAX_DIST  = 32'sh0064_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid, start_ready;
    vec3        ray_origin, ray_dir, sdf_p;
    logic       sdf_valid_out, sdf_valid_in;
    fp          sdf_dist;
    logic       res_valid, res_ready, res_hit;
    fp          res_t;
    logic [7:0] res_steps;
    logic       stub_valid, spur_valid;

    assign sdf_valid_in = stub_valid | spur_valid;

    always #5 clk = ~clk;

    ray_march_stepper #(.MAX_STEPS(MAX_STEPS), .HIT_EPS(HIT_EPS), .MAX_DIST(MAX_DIST)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .ray_origin(ray_origin), .ray_dir(ray_dir),
        .sdf_p(sdf_p), .sdf_valid_out(sdf_valid_out),
        .sdf_dist(sdf_dist), .sdf_valid_in(sdf_valid_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hit(res_hit), .res_t(res_t), .res_steps(res_steps)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    int     mode  = 0;
    int     lat   = 1;
    bit     stub_en   = 1'b1;
    bit     no_result = 1'b0;
    vec3    exp_p_q[$];
    logic   exp_hit;
    fp      exp_t;
    int     exp_steps;
    vec3    stub_p, cmp_e;
    logic   prev_svo = 1'b0, prev_rv = 1'b0;
    logic   got_hit;
    fp      got_t;
    logic [7:0] got_steps;
    time    resp_time, seen_time;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Distance functions offered by the stub: unit sphere, or constants.
    function automatic fp dist_of(input int m, input vec3 p);
        real x, y, z, d;
        case (m)
            0: begin
                x = $itor(p.x) / 65536.0;
                y = $itor(p.y) / 65536.0;
                z = $itor(p.z) / 65536.0;
                d = $sqrt(x * x + y * y + z * z) - 1.0;
                return fp'($rtoi(d * 65536.0));
            end
            1:       return 32'sh000A_0000;
            2:       return 32'sh0000_8000;
            default: return -32'sh0000_4000;
        endcase
    endfunction

    function automatic fp scale_add(input fp o, input fp t, input fp d);
        longint prod;
        prod = longint'(t) * longint'(d);
        return o + fp'(prod >>> 16);
    endfunction

    // March the ray in plain arithmetic: expected requests plus final result.
    task automatic model_ray(input vec3 o, input vec3 d);
        fp      t;
        int     s;
        fp      dv;
        longint tn;
        vec3    p;
        t = 0;
        s = 0;
        exp_p_q.delete();
        forever begin
            p.x = scale_add(o.x, t, d.x);
            p.y = scale_add(o.y, t, d.y);
            p.z = scale_add(o.z, t, d.z);
            exp_p_q.push_back(p);
            dv = dist_of(mode, p);
            s++;
            if (dv < HIT_EPS) begin
                exp_hit = 1'b1; exp_t = t; exp_steps = s;
                break;
            end
            tn = longint'(t) + longint'(dv);
            if (tn > 64'sh7FFF_FFFF) tn = 64'sh7FFF_FFFF;
            if (tn >= longint'(MAX_DIST) || s == MAX_STEPS) begin
                exp_hit = 1'b0; exp_t = fp'(tn); exp_steps = s;
                break;
            end
            t = fp'(tn);
        end
    endtask

    // SDF stub: answers each request after lat cycles.
    initial begin
        stub_valid = 1'b0;
        sdf_dist   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (stub_en && sdf_valid_out) begin
                stub_p = sdf_p;
                repeat (lat - 1) begin
                    @(posedge clk);
                    #1;
                end
                sdf_dist   = dist_of(mode, stub_p);
                stub_valid = 1'b1;
                @(posedge clk);
                resp_time = $time;
                #1 stub_valid = 1'b0;
            end
        end
    end

    // Compare process: requests, result, and result stability while held.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sdf_valid_out) begin
                    chk("req_pulse_width", prev_svo, 0);
                    chk("req_start_ready", start_ready, 0);
                    chk("pending_reqs", exp_p_q.size() > 0, 1);
                    if (exp_p_q.size() > 0) begin
                        cmp_e = exp_p_q.pop_front();
                        chk("req_px", sdf_p.x, cmp_e.x);
                        chk("req_py", sdf_p.y, cmp_e.y);
                        chk("req_pz", sdf_p.z, cmp_e.z);
                    end
                end
                if (no_result) begin
                    chk("res_after_reset", res_valid, 0);
                end else if (res_valid) begin
                    chk("busy_start_ready", start_ready, 0);
                    if (!prev_rv) begin
                        got_hit = res_hit; got_t = res_t; got_steps = res_steps;
                        chk("model_hit", res_hit, exp_hit);
                        chk("model_t", res_t, exp_t);
                        chk("model_steps", res_steps, exp_steps);
                        $display("result: hit=%0d t=%h steps=%0d", res_hit, res_t, res_steps);
                    end else begin
                        chk("hold_hit", res_hit, got_hit);
                        chk("hold_t", res_t, got_t);
                        chk("hold_steps", res_steps, got_steps);
                    end
                end
            end
            prev_svo = sdf_valid_out;
            prev_rv  = res_valid;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_start_ready"}, start_ready, 1);
        chk({tag, "_sdf_valid_out"}, sdf_valid_out, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_hit"}, res_hit, 0);
        chk({tag, "_sdf_p_zero"}, sdf_p == '0, 1);
        chk({tag, "_res_t"}, res_t, 0);
        chk({tag, "_res_steps"}, res_steps, 0);
    endtask

    task automatic start_ray(input vec3 o, input vec3 d);
        model_ray(o, d);
        ray_origin  = o;
        ray_dir     = d;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic wait_result();
        for (int i = 0; i < 3000 && !res_valid; i++) begin
            @(posedge clk);
            #1;
        end
        seen_time = $time;
        chk("result_timeout", res_valid, 1);
        chk("reqs_left", exp_p_q.size(), 0);
    endtask

    task automatic accept_result();
        @(posedge clk);
        #1;
        chk("accept_res_valid", res_valid, 0);
        chk("accept_start_ready", start_ready, 1);
    endtask

    task automatic check_lit(input string tag, input logic h, input fp t, input int s);
        chk({tag, "_hit"}, res_hit, h);
        chk({tag, "_t"}, res_t, t);
        chk({tag, "_steps"}, res_steps, s);
    endtask

    vec3 o_m3, o_zero, dir_z, o_off;

    initial begin
        o_m3   = '{x: 0, y: 0, z: -32'sh0003_0000};
        o_zero = '{x: 0, y: 0, z: 0};
        o_off  = '{x: 32'sh0000_8000, y: -32'sh0001_0000, z: 0};
        dir_z  = '{x: 0, y: 0, z: FP_ONE};
        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b1; spur_valid = 1'b0;
        ray_origin = '0; ray_dir = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;

        mode = 0; lat = 3;
        run_t1("t1");

        mode = 1; lat = 2;
        start_ray(o_zero, dir_z); wait_result();
        check_lit("t2", 1'b0, 32'sh0064_0000, 10);
        accept_result();

        mode = 2; lat = 1;
        start_ray(o_off, dir_z); wait_result();
        check_lit("t3", 1'b0, 32'sh0020_0000, 64);
        accept_result();

        mode = 3; lat = 1;
        start_ray(o_zero, dir_z); wait_result();
        check_lit("t4", 1'b1, 0, 1);
        chk("t4_latency_ns", longint'(seen_time - resp_time), 1);
        accept_result();

        // Backpressure with spurious sdf_valid_in while the result is held.
        mode = 0; lat = 3; res_ready = 1'b0;
        start_ray(o_m3, dir_z); wait_result();
        for (int i = 0; i < 5; i++) begin
            spur_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            chk("bp_start_ready", start_ready, 0);
            chk("bp_res_valid", res_valid, 1);
        end
        spur_valid = 1'b0;
        check_lit("t5", 1'b1, 32'sh0002_0000, 2);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_ready_after_accept", start_ready, 1);
        mode = 3; lat = 1;
        start_ray(o_zero, dir_z);
        chk("t5_start_taken", start_ready, 0);
        wait_result();
        check_lit("t5b", 1'b1, 0, 1);
        accept_result();

        // Reset while waiting for a distance; the late answer must be ignored.
        mode = 0; lat = 3;
        start_ray(o_m3, dir_z);
        for (int i = 0; i < 20 && !sdf_valid_out; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_req_seen", sdf_valid_out, 1);
        @(posedge clk);
        #1;
        rst = 1'b1; no_result = 1'b1;
        exp_p_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset("t6");
        repeat (10) @(posedge clk);
        #1;
        chk("t6_still_idle", start_ready, 1);
        no_result = 1'b0;
        run_t1("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic run_t1(input string tag);
        start_ray(o_m3, dir_z);
        wait_result();
        check_lit(tag, 1'b1, 32'sh0002_0000, 2);
        accept_result();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
